// File: rtl/display_index_frontend.sv
// Display front-end: DISP_SEL digit-mux divider, switch priority encoder, hex-to-7-seg decoder.
// Every output is registered with 1-cycle latency; there is no flow control and all inputs are sampled every cycle.
module display_index_frontend #(
  parameter int DIV_COUNT = 50000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] SWITCHES,
  input  logic [3:0] SEG_IN,
  output logic       DISP_SEL,
  output logic       TICK,
  output logic [3:0] INDEX,
  output logic       INDEX_VALID,
  output logic [7:0] DOUT
);

  localparam int CW = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV_COUNT - 1);

  logic [CW-1:0] cnt;
  logic [2:0]    idx_nxt;
  logic [7:0]    seg_nxt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt      <= '0;
      DISP_SEL <= 1'b0;
      TICK     <= 1'b0;
    end else if (cnt == LAST) begin
      cnt      <= '0;
      DISP_SEL <= ~DISP_SEL;
      TICK     <= 1'b1;
    end else begin
      cnt  <= cnt + 1'b1;
      TICK <= 1'b0;
    end
  end

  // Scan from the top down so the lowest-numbered set switch is assigned last and wins.
  always_comb begin
    idx_nxt = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (SWITCHES[i]) idx_nxt = 3'(i);
    end
  end

  always_comb begin
    seg_nxt = 8'h00;
    case (SEG_IN)
      4'h0: seg_nxt = 8'h3F;
      4'h1: seg_nxt = 8'h06;
      4'h2: seg_nxt = 8'h5B;
      4'h3: seg_nxt = 8'h4F;
      4'h4: seg_nxt = 8'h66;
      4'h5: seg_nxt = 8'h6D;
      4'h6: seg_nxt = 8'h7D;
      4'h7: seg_nxt = 8'h07;
      4'h8: seg_nxt = 8'h7F;
      4'h9: seg_nxt = 8'h6F;
      4'hA: seg_nxt = 8'h77;
      4'hB: seg_nxt = 8'h7C;
      4'hC: seg_nxt = 8'h39;
      4'hD: seg_nxt = 8'h5E;
      4'hE: seg_nxt = 8'h79;
      4'hF: seg_nxt = 8'h71;
      default: seg_nxt = 8'h00;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      INDEX       <= 4'd0;
      INDEX_VALID <= 1'b0;
      DOUT        <= 8'h00;
    end else begin
      INDEX       <= {1'b0, idx_nxt};
      INDEX_VALID <= |SWITCHES;
      DOUT        <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_display_index_frontend.sv
// Randomized bench for display_index_frontend with a cycle-count reference model, DIV_COUNT = 4 and 1.
module tb_display_index_frontend;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] SWITCHES = 8'h00;
  logic [3:0] SEG_IN = 4'h0;

  logic       disp4, tick4, valid4, disp1, tick1, valid1;
  logic [3:0] index4, index1;
  logic [7:0] dout4, dout1;

  int compared = 0;
  int mismatched = 0;

  // Model state: edges since reset was released, plus expected registered outputs.
  int         k = 0;
  logic [3:0] e_idx = 4'd0;
  logic       e_valid = 1'b0;
  logic [7:0] e_dout = 8'h00;

  logic [7:0] seg_tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                               8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  always #5 CLK = ~CLK;

  display_index_frontend #(.DIV_COUNT(4)) dut4 (
    .CLK(CLK), .RST(RST), .SWITCHES(SWITCHES), .SEG_IN(SEG_IN),
    .DISP_SEL(disp4), .TICK(tick4), .INDEX(index4), .INDEX_VALID(valid4), .DOUT(dout4)
  );

  display_index_frontend #(.DIV_COUNT(1)) dut1 (
    .CLK(CLK), .RST(RST), .SWITCHES(SWITCHES), .SEG_IN(SEG_IN),
    .DISP_SEL(disp1), .TICK(tick1), .INDEX(index1), .INDEX_VALID(valid1), .DOUT(dout1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (k=%0d, t=%0t)", tag, got, exp, k, $time);
    end
  endtask

  function automatic logic [3:0] lowest_set(input logic [7:0] s);
    for (int i = 0; i < 8; i++) begin
      if (s[i]) return 4'(i);
    end
    return 4'd0;
  endfunction

  task automatic step(input logic r, input logic [7:0] sw, input logic [3:0] seg);
    @(negedge CLK);
    RST = r;
    SWITCHES = sw;
    SEG_IN = seg;
    @(posedge CLK);
    #1;
    if (r) begin
      k = 0;
      e_idx = 4'd0;
      e_valid = 1'b0;
      e_dout = 8'h00;
    end else begin
      k++;
      e_idx = lowest_set(sw);
      e_valid = (sw != 8'h00);
      e_dout = seg_tab[seg];
    end
    // DISP_SEL flips after every D cycles of run time, TICK marks each such boundary.
    check("disp_sel_d4", 32'(disp4), 32'((k / 4) % 2));
    check("tick_d4",     32'(tick4), 32'(k > 0 && k % 4 == 0));
    check("disp_sel_d1", 32'(disp1), 32'(k % 2));
    check("tick_d1",     32'(tick1), 32'(k > 0));
    check("index",       32'(index4), 32'(e_idx));
    check("index_valid", 32'(valid4), 32'(e_valid));
    check("dout",        32'(dout4), 32'(e_dout));
    check("dout_dp",     32'(dout4[7]), 32'd0);
    check("index_d1",    32'(index1), 32'(e_idx));
    check("dout_d1",     32'(dout1), 32'(e_dout));
  endtask

  initial begin
    logic [7:0] sw_seq [5];
    sw_seq = '{8'h00, 8'h01, 8'h80, 8'hA4, 8'hFF};

    step(1'b1, 8'h00, 4'h0);
    step(1'b1, 8'h00, 4'h0);
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 4'h0);

    // Reset in the middle of a half-period, then watch the first toggle after release.
    while (k % 4 != 2) step(1'b0, 8'h5A, 4'h3);
    step(1'b1, 8'h5A, 4'h3);
    for (int i = 0; i < 9; i++) step(1'b0, 8'h00, 4'h0);

    foreach (sw_seq[i]) step(1'b0, sw_seq[i], 4'h0);
    for (int v = 0; v < 16; v++) step(1'b0, 8'h00, 4'(v));

    // Simultaneous switch and nibble change on the edge where DISP_SEL toggles.
    while (k % 4 != 3) step(1'b0, 8'h00, 4'h0);
    step(1'b0, 8'h10, 4'hA);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h10, 4'hA);

    repeat (400) step($urandom_range(0, 39) == 0, 8'($urandom), 4'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/display_index_frontend.md
Name: display_index_frontend

Overview:
Display/selection front-end for the 4-bit ALU board. It bundles three independent sub-functions behind one clock and one reset:
- a clock divider that produces the dynamic-lighting (digit multiplex) select signal;
- a priority encoder that turns the 8 data switches into an index-register address;
- a hex-to-7-segment decoder driving DOUT.

The ALU core and the output selector consume INDEX and DISP_SEL. The digit mux feeds SEG_IN.

Parameters:
DIV_COUNT, 50000, clock cycles per DISP_SEL half-period; legal range >= 1.

Ports:
CLK  input  1  system clock; all state updates on the rising edge.
RST  input  1  reset, synchronous, active-high.
SWITCHES  input  8  switch vector {SW8,SW7,SW6,SW5,SW4,SW3,SW2,SW1}; bit 0 = SW1.
SEG_IN  input  4  hex nibble to display.
DISP_SEL  output  1  divided square wave (CE_OUT); selects which digit is lit.
TICK  output  1  one-cycle pulse on every DISP_SEL toggle.
INDEX  output  4  encoded switch index, 0..7.
INDEX_VALID  output  1  1 when at least one switch is set.
DOUT  output  8  segment pattern {dp,g,f,e,d,c,b,a}, active-high.

Behaviour:
- Reset (RST=1 at a rising edge) forces the following registered values. All other behaviour applies only when RST=0.
  - Divider counter = 0, DISP_SEL = 0, TICK = 0.
  - INDEX = 0, INDEX_VALID = 0.
  - DOUT = 8'h00 (blank).
- Reset mid-count discards the partial count. The next DISP_SEL toggle occurs DIV_COUNT cycles after reset is released.
- Divider:
  - Counter width is ceil(log2(DIV_COUNT)), minimum 1 bit.
  - Each cycle: if counter == DIV_COUNT-1, then counter <= 0, DISP_SEL <= ~DISP_SEL, TICK <= 1. Otherwise counter <= counter+1 and TICK <= 0.
  - DISP_SEL period = 2*DIV_COUNT cycles, 50% duty.
  - DIV_COUNT = 1: DISP_SEL toggles every cycle and TICK stays high continuously.
- Index selector:
  - Registered, 1-cycle latency.
  - The lowest-numbered set bit wins: SWITCHES[0] set -> INDEX = 0, ..., SWITCHES[7] only -> INDEX = 7.
  - INDEX[3] is always 0.
  - SWITCHES = 0 -> INDEX = 0, INDEX_VALID = 0.
  - Any set bit -> INDEX_VALID = 1.
  - Switch changes are sampled every cycle; no debouncing in this block.
- Decoder:
  - Registered, 1-cycle latency. dp (bit 7) is always 0.
  - SEG_IN 0..F maps to DOUT = 3F, 06, 5B, 4F, 66, 6D, 7D, 07, 7F, 6F, 77, 7C, 39, 5E, 79, 71 (hex).
  - Every 4-bit input value is defined; there are no X outputs.
- All three sub-functions run concurrently and do not interact. Simultaneous input changes are each reflected on the next edge.

Test Plan:
1. DIV_COUNT = 4, assert RST for 2 cycles, then release:
   - DISP_SEL reads 0 for the first 4 cycles, then 1 for 4 cycles, repeating.
   - TICK pulses exactly once every 4 cycles, coincident with each toggle.
2. Assert RST in the middle of a half-period (counter = 2):
   - DISP_SEL = 0, TICK = 0, DOUT = 00, INDEX = 0 on the next edge.
   - The first toggle comes 4 cycles after release.
3. SWITCHES sequence 8'h00, 8'h01, 8'h80, 8'hA4, 8'hFF:
   - INDEX / INDEX_VALID one cycle later = 0/0, 0/1, 7/1, 2/1, 0/1.
4. Sweep SEG_IN 0..F, one value per cycle:
   - DOUT one cycle later matches the 16-entry table exactly; DOUT[7] = 0 throughout.
5. Drive SWITCHES = 8'h10 and SEG_IN = 4'hA on the same edge, with DISP_SEL about to toggle:
   - Next cycle: INDEX = 4, INDEX_VALID = 1, DOUT = 77.
   - The toggle occurs on schedule.
6. DIV_COUNT = 1:
   - DISP_SEL alternates 0,1,0,1 every cycle after reset and TICK stays 1.
